// File: rtl/audio_pkg.sv
// Shared audio types and clocking constants for the synthesizer sample path.
package audio_pkg;

   typedef logic [31:0] sample_t;

   localparam int unsigned CLK_MHZ          = 100;
   localparam int unsigned SAMPLE_RATE_HZ   = 44100;
   localparam int unsigned DEFAULT_TICK_DIV = 2268;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with a registered head word and occupancy count.
module sync_fifo2 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [1:0]       count_q;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count_q == 2'd0) head_q <= din;
               else                 tail_q <= din;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the new word lands behind whatever stays
               if (count_q == 2'd1) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head_q;
   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign count = count_q;

endmodule

// File: rtl/bram_sample_reader.sv
// Tick-paced looping reader of the audio sample BRAM feeding a valid/ready stream.
// Define BRAM_READER_STATS_EN to add the saturating overrun_count output.
module bram_sample_reader
   import audio_pkg::*;
#(
   parameter int unsigned BRAM_DEPTH   = 2048,
   parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [$clog2(BRAM_DEPTH):0] length,
   output logic [31:0]                 BRAM_addr,
   output logic                        BRAM_clk,
   output logic [31:0]                 BRAM_din,
   input  logic [31:0]                 BRAM_dout,
   output logic                        BRAM_en,
   output logic                        BRAM_rst,
   output logic [3:0]                  BRAM_we,
   output logic [31:0]                 m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        wrap,
   output logic                        overrun
`ifdef BRAM_READER_STATS_EN
   ,
   output logic [15:0]                 overrun_count
`endif
);

   localparam int unsigned AW = $clog2(BRAM_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0]           tick_cnt_q;
   logic [AW-1:0]           addr_q;
   logic [LW-1:0]           length_q;
   logic [LW-1:0]           len_clamped;
   logic [READ_LATENCY-1:0] tag_q;
   logic [2:0]              inflight;
   logic [1:0]              fifo_count;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    tick;
   logic                    last;
   logic                    pop;
   logic                    credit_ok;
   logic                    active;
   logic                    issue;
   logic                    drop;
   logic                    tag_exit;
   sample_t                 head;

   assign tick        = (tick_cnt_q == CW'(TICK_DIV - 1));
   assign len_clamped = (length > LW'(BRAM_DEPTH)) ? LW'(BRAM_DEPTH) : length;
   assign last        = ({1'b0, addr_q} == (length_q - LW'(1)));
   assign pop         = m_valid && m_ready;
   assign tag_exit    = tag_q[READ_LATENCY-1];

   always_comb begin
      inflight = 3'd0;
      for (int i = 0; i < int'(READ_LATENCY); i++) inflight = inflight + 3'(tag_q[i]);
   end

   // a same-cycle pop returns its credit before the issue decision
   assign credit_ok = ((3'(fifo_count) + inflight) - 3'(pop)) < 3'd2;
   assign active    = tick && enable && (length_q != '0) && !rst;
   assign issue     = active && credit_ok;
   assign drop      = active && !credit_ok;
   assign wrap      = issue && last;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         addr_q     <= '0;
         length_q   <= len_clamped;
         tag_q      <= '0;
         overrun    <= 1'b0;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
         if (issue) addr_q <= last ? '0 : addr_q + AW'(1);
         if (wrap || (length_q == '0)) length_q <= len_clamped;
         tag_q[0] <= issue;
         for (int i = 1; i < int'(READ_LATENCY); i++) tag_q[i] <= tag_q[i-1];
         if (drop) overrun <= 1'b1;
      end
   end

`ifdef BRAM_READER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) overrun_count <= 16'd0;
      else if (drop && (overrun_count != 16'hFFFF)) overrun_count <= overrun_count + 16'd1;
   end
`endif

   sync_fifo2 #(.WIDTH(32)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_exit),
      .din   (BRAM_dout),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // the credit rule must keep a returning read from hitting a full FIFO
   no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_full && tag_exit && !pop));

   assign m_data    = head;
   assign m_valid   = !fifo_empty;
   assign BRAM_addr = 32'(addr_q) << 2;
   assign BRAM_clk  = clk;
   assign BRAM_din  = 32'd0;
   assign BRAM_en   = 1'b1;
   assign BRAM_rst  = rst;
   assign BRAM_we   = 4'd0;

endmodule

// File: tb/tb_bram_sample_reader.sv
// Scoreboard bench for bram_sample_reader against a transaction-level model of the loop.
module tb_bram_sample_reader;

   localparam int unsigned DEPTH = 2048;
   localparam int unsigned TD    = 4;
   parameter  int unsigned LAT   = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [11:0] length = 12'd0;
   logic        m_ready = 1'b0;
   logic [31:0] BRAM_addr, BRAM_din, BRAM_dout, m_data;
   logic        BRAM_clk, BRAM_en, BRAM_rst, m_valid, wrap, overrun;
   logic [3:0]  BRAM_we;
`ifdef BRAM_READER_STATS_EN
   logic [15:0] overrun_count;
`endif

   always #5 clk = ~clk;

   bram_sample_reader #(.BRAM_DEPTH(DEPTH), .TICK_DIV(TD), .READ_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .enable(enable), .length(length),
      .BRAM_addr(BRAM_addr), .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din),
      .BRAM_dout(BRAM_dout), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst),
      .BRAM_we(BRAM_we), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .wrap(wrap), .overrun(overrun)
`ifdef BRAM_READER_STATS_EN
      , .overrun_count(overrun_count)
`endif
   );

   // BRAM with registered output, optionally one extra output register
   logic [31:0] mem [DEPTH];
   logic [31:0] rd1, rd2;
   always @(posedge clk) begin
      rd1 <= mem[BRAM_addr[12:2]];
      rd2 <= rd1;
   end
   assign BRAM_dout = (LAT == 1) ? rd1 : rd2;

   int errors = 0;
   int checks = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int clampl(int l);
      return (l > int'(DEPTH)) ? int'(DEPTH) : l;
   endfunction

   // model state: loop position, in-flight/buffered samples as ready times
   longint      gcyc = 0;
   int          mcnt = 0, maddr = 0, mlq = 0, mocnt = 0;
   bit          movr = 0, after_rst = 0;
   longint      rdy_q[$];
   logic [31:0] exp_q[$];

   always @(negedge clk) begin : model
      bit vexp, mpop, tick, credit, act, iss, lst;
      gcyc++;
      if (rst) begin
         mcnt = 0; maddr = 0; mlq = clampl(int'(length)); movr = 0; mocnt = 0;
         rdy_q.delete(); exp_q.delete(); after_rst = 1;
      end else begin
         vexp = (rdy_q.size() > 0) && (rdy_q[0] <= gcyc);
         chk("m_valid", 32'(m_valid), 32'(vexp));
         chk("overrun", 32'(overrun), 32'(movr));
`ifdef BRAM_READER_STATS_EN
         chk("overrun_count", 32'(overrun_count), 32'(mocnt));
`endif
         if (after_rst) begin
            chk("m_data_after_rst", m_data, 32'd0);
            chk("bram_en", 32'(BRAM_en), 32'd1);
            chk("bram_we", 32'(BRAM_we), 32'd0);
            chk("bram_din", BRAM_din, 32'd0);
            chk("bram_rst", 32'(BRAM_rst), 32'(rst));
            chk("bram_clk", 32'(BRAM_clk), 32'(clk));
            after_rst = 0;
         end
         mpop   = vexp && m_ready;
         tick   = (mcnt == int'(TD) - 1);
         credit = (rdy_q.size() - int'(mpop)) < 2;
         act    = tick && enable && (mlq != 0);
         iss    = act && credit;
         lst    = iss && (maddr == mlq - 1);
         chk("wrap", 32'(wrap), 32'(lst));
         if (iss) chk("bram_addr", BRAM_addr, 32'(maddr * 4));
         if (mpop) void'(rdy_q.pop_front());
         if (iss) begin
            rdy_q.push_back(gcyc + longint'(LAT) + 1);
            exp_q.push_back(mem[maddr]);
            maddr = lst ? 0 : maddr + 1;
         end
         if (lst || mlq == 0) mlq = clampl(int'(length));
         if (act && !credit) begin
            movr = 1;
            if (mocnt < 65535) mocnt++;
         end
         mcnt = tick ? 0 : mcnt + 1;
      end
   end

   logic        hold_v = 1'b0;
   logic [31:0] hold_d = 32'd0;

   always @(negedge clk) begin : monitor
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v && m_valid) chk("m_data_stable", m_data, hold_d);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_sample: got %0d expected none at %0t", m_data, $time);
            end else begin
               chk("m_data", m_data, exp_q.pop_front());
            end
         end
         hold_v = m_valid && !m_ready;
         hold_d = m_data;
      end
   end

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = (i < 16) ? 32'(100 + i) : $urandom;
      rst = 1'b1; enable = 1'b1; length = 12'd4; m_ready = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(48);
      m_ready = 1'b0; cycles(20);
      m_ready = 1'b1; cycles(24);
      length = 12'd2; cycles(40);
      length = 12'd4; cycles(40);
      enable = 1'b0; cycles(12);
      enable = 1'b1; cycles(24);
      cycles($urandom_range(0, 3));
      rst = 1'b1; cycles(1);
      rst = 1'b0; cycles(30);
      length = 12'd0; cycles(20);
      length = 12'd3; cycles(40);
      for (int k = 0; k < 3000; k++) begin
         m_ready = ($urandom % 4) != 0;
         if ($urandom % 50 == 0) enable = ~enable;
         if ($urandom % 200 == 0) length = 12'($urandom_range(0, 12));
         rst = ($urandom % 700 == 0);
         cycles(1);
      end
      rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
      length = 12'd3000;
      cycles(8192 + 300);
      length = 12'd4;
      cycles(40);
      enable = 1'b0;
      cycles(20);
      chk("drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
